pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB). It generates the stage enables, bubbles and flushes, and the EX-stage forwarding selects. It freezes the pipeline while a data-memory access is outstanding and keeps stall, flush and timeout status. It fills the currently empty Controller slot in the CPU top level.

Parameters:
MAX_WAIT, 16, cycles a memory access may stay un-ready before mem_timeout sets (2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-low
id_opcode  in  7  opcode of instruction in IF/ID
id_rs1  in  5  rs1 field of IF/ID instruction
id_rs2  in  5  rs2 field of IF/ID instruction
id_ex_rd  in  5  ID_EX_rd
id_ex_is_load  in  1  instruction in EX is a load
ex_rs1  in  5  rs1 of instruction in EX
ex_rs2  in  5  rs2 of instruction in EX
ex_mem_rd  in  5  EX_MEM_rd
ex_mem_regwrite  in  1  instruction in MEM writes rd
ex_mem_is_branch  in  1  taken branch/jump resolved in MEM
ex_mem_mem_req  in  1  load or store in MEM
mem_ready  in  1  data memory completes access this cycle
mem_wb_rd  in  5  MEM_WB_rd
mem_wb_regwrite  in  1  instruction in WB writes rd
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_bubble  out  1  ID/EX loads NOP; covers both flush and bubble
ex_mem_flush  out  1  EX/MEM loads NOP
mem_wb_bubble  out  1  MEM/WB loads NOP
fwd_a  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM result
fwd_b  out  2  same for operand B
mem_timeout  out  1  sticky: access exceeded MAX_WAIT
stall_cnt  out  CNT_W  cycles with pc_en=0, excluding reset
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- State register: RUN and MEM_WAIT. Wait counter wait_cnt is 8 bits.
- Reset (rst=0, asynchronous):
  - State RUN; wait_cnt, stall_cnt, flush_cnt and mem_timeout all 0.
  - While rst=0: all enables 0, all flush/bubble outputs 1, fwd_a = fwd_b = 00.
- Source-use decode:
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used by 0110011, 0111011, store 0100011 and branch 1100011.
- Forwarding (combinational, independent of state):
  - fwd_a = 10 if ex_mem_regwrite and ex_mem_rd != 0 and ex_mem_rd == ex_rs1.
  - Else 01 if mem_wb_regwrite and mem_wb_rd != 0 and mem_wb_rd == ex_rs1.
  - Else 00. fwd_b is identical using ex_rs2.
- Control outputs are combinational from state and inputs. Priority, highest first:
  1. Memory wait, when ex_mem_mem_req=1 and mem_ready=0:
     - pc_en, if_id_en, id_ex_en and ex_mem_en all 0; mem_wb_bubble=1; all flushes 0.
     - Next state MEM_WAIT; wait_cnt increments, saturating at 255.
     - When wait_cnt reaches MAX_WAIT-1 and ready is still 0, mem_timeout sets to 1 and stays set until reset.
  2. Taken branch (ex_mem_is_branch=1):
     - All enables 1; if_id_flush, id_ex_bubble and ex_mem_flush are 1, squashing 3 younger instructions.
     - flush_cnt increments by 1.
  3. Load-use: id_ex_is_load=1, id_ex_rd != 0, and id_ex_rd matches a used id_rs1 or id_rs2:
     - pc_en=0 and if_id_en=0; id_ex_bubble=1; id_ex_en and ex_mem_en stay 1.
     - Lasts exactly one cycle, because the bubble clears the hazard.
  4. Otherwise all enables 1 and all flushes/bubbles 0.
- MEM_WAIT to RUN occurs in the cycle mem_ready=1. That cycle behaves as RUN, so branch/load-use rules apply, and wait_cnt clears to 0.
- A branch can never coexist with a memory request in MEM. If both are asserted, memory wait wins and the branch is held until ready.
- stall_cnt increments on every clock edge where pc_en=0 and rst=1. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-wait: returns to RUN immediately and clears the counters; mem_timeout clears.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> pc_en=0, all flushes=1, counters=0; after release with no hazards -> all enables 1, fwd=00.
- Forwarding: ex_rs1=5, ex_mem_rd=5, ex_mem_regwrite=1, mem_wb_rd=5, mem_wb_regwrite=1 -> fwd_a=10. Drop ex_mem_regwrite -> fwd_a=01. Set both rd=0 -> fwd_a=00.
- Load-use: id_ex_is_load=1, id_ex_rd=7, id_opcode=0110011, id_rs2=7 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1, and stall_cnt becomes 1. Repeat with id_opcode=0110111 (LUI) -> no stall.
- Branch: ex_mem_is_branch=1 for one cycle -> if_id_flush, id_ex_bubble and ex_mem_flush=1, pc_en=1, flush_cnt=1.
- Memory wait: ex_mem_mem_req=1 with mem_ready low for 4 cycles then high -> 4 frozen cycles with mem_wb_bubble=1, stall_cnt=4, state back to RUN, mem_timeout=0. With MAX_WAIT=4 and ready low for 6 cycles -> mem_timeout=1 from the 4th cycle and held.
- Priority: assert memory wait, load-use and branch together -> only the freeze is applied. Once mem_ready=1 -> branch flush applies that cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV64 pipeline:
// stage enables, bubbles/flushes, EX forwarding and memory-wait freeze.
module pipe_hazard_ctrl #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_is_load,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_mem_rd,
   input  logic             ex_mem_regwrite,
   input  logic             ex_mem_is_branch,
   input  logic             ex_mem_mem_req,
   input  logic             mem_ready,
   input  logic [4:0]       mem_wb_rd,
   input  logic             mem_wb_regwrite,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, MEM_WAIT} state_e;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_RW    = 7'b0111011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [7:0] TO_LIM   = 8'(MAX_WAIT - 1);

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic use_rs1, use_rs2, lu_hit;
   logic mem_wait, br_go, lu_go;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs)
         return 2'b10;
      else if (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign use_rs1 = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign use_rs2 = id_opcode inside {OP_R, OP_RW, OP_ST, OP_BR};

   assign lu_hit = id_ex_is_load && id_ex_rd != 5'd0 &&
                   ((use_rs1 && id_ex_rd == id_rs1) ||
                    (use_rs2 && id_ex_rd == id_rs2));

   // A pending access outranks everything; a branch in MEM is held until ready.
   assign mem_wait = ex_mem_mem_req && !mem_ready;
   assign br_go    = !mem_wait && ex_mem_is_branch;
   assign lu_go    = !mem_wait && !br_go && lu_hit;

   assign fwd_a = rst ? fwd_sel(ex_rs1) : 2'b00;
   assign fwd_b = rst ? fwd_sel(ex_rs2) : 2'b00;

   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
      state_d       = RUN;
      wait_cnt_d    = 8'd0;
      timeout_d     = timeout_q;
      stall_d       = stall_q;
      flush_d       = flush_q;

      unique case (1'b1)
         mem_wait: begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            if (state_q == RUN)
               wait_cnt_d = 8'd1;
            else if (wait_cnt_q == 8'hFF)
               wait_cnt_d = 8'hFF;
            else
               wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_q >= TO_LIM)
               timeout_d = 1'b1;
         end
         br_go: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            flush_d      = flush_q + 1'b1;
         end
         lu_go: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
         default: ;
      endcase

      if (!pc_en)
         stall_d = stall_q + 1'b1;

      if (!rst) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_flush  = 1'b1;
         mem_wb_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
         stall_q    <= '0;
         flush_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_cnt   = stall_q;
   assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl against a rule-level model;
// a second instance with MAX_WAIT=4 exercises the timeout boundary.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, id_ex_rd, ex_rs1, ex_rs2;
   logic [4:0] ex_mem_rd, mem_wb_rd;
   logic       id_ex_is_load, ex_mem_regwrite, ex_mem_is_branch;
   logic       ex_mem_mem_req, mem_ready, mem_wb_regwrite;

   logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic        if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic        mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4;
   logic        if_id_flush4, id_ex_bubble4, ex_mem_flush4, mem_wb_bubble4;
   logic [1:0]  fwd_a4, fwd_b4;
   logic        mem_timeout4;
   logic [31:0] stall_cnt4, flush_cnt4;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] m_stall, m_flush, m_run;
   logic        m_to16, m_to4;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_is_load(id_ex_is_load),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
      .ex_mem_is_branch(ex_mem_is_branch), .ex_mem_mem_req(ex_mem_mem_req),
      .mem_ready(mem_ready), .mem_wb_rd(mem_wb_rd),
      .mem_wb_regwrite(mem_wb_regwrite),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush),
      .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) u_dut4 (
      .clk(clk), .rst(rst),
      .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_is_load(id_ex_is_load),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
      .ex_mem_is_branch(ex_mem_is_branch), .ex_mem_mem_req(ex_mem_mem_req),
      .mem_ready(mem_ready), .mem_wb_rd(mem_wb_rd),
      .mem_wb_regwrite(mem_wb_regwrite),
      .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
      .ex_mem_en(ex_mem_en4), .if_id_flush(if_id_flush4),
      .id_ex_bubble(id_ex_bubble4), .ex_mem_flush(ex_mem_flush4),
      .mem_wb_bubble(mem_wb_bubble4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
      .mem_timeout(mem_timeout4), .stall_cnt(stall_cnt4),
      .flush_cnt(flush_cnt4)
   );

   // ---------------- model ----------------
   function automatic logic rs1_used(input logic [6:0] op);
      return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
   endfunction

   function automatic logic rs2_used(input logic [6:0] op);
      return op == 7'h33 || op == 7'h3b || op == 7'h23 || op == 7'h63;
   endfunction

   // {pc,ifid,idex,exmem, if_id_flush,id_ex_bubble,ex_mem_flush,mem_wb_bubble}
   function automatic logic [7:0] exp_ctrl();
      logic frz, br, lu, hit;
      if (!rst) return 8'b0000_1111;
      frz = ex_mem_mem_req && !mem_ready;
      br  = ex_mem_is_branch && !frz;
      hit = (rs1_used(id_opcode) && id_rs1 == id_ex_rd) ||
            (rs2_used(id_opcode) && id_rs2 == id_ex_rd);
      lu  = id_ex_is_load && id_ex_rd != 0 && hit && !frz && !br;
      return {!(frz || lu), !(frz || lu), !frz, !frz, br, br || lu, br, frz};
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (!rst) return 2'd0;
      if (ex_mem_regwrite && ex_mem_rd == rs && rs != 0) return 2'd2;
      if (mem_wb_regwrite && mem_wb_rd == rs && rs != 0) return 2'd1;
      return 2'd0;
   endfunction

   always @(posedge clk or negedge rst) begin
      logic [7:0] c;
      if (!rst) begin
         m_stall <= 0;
         m_flush <= 0;
         m_run   <= 0;
         m_to16  <= 0;
         m_to4   <= 0;
      end else begin
         c = exp_ctrl();
         if (!c[7]) m_stall <= m_stall + 1;
         if (c[3])  m_flush <= m_flush + 1;
         if (c[0]) begin
            m_run <= m_run + 1;
            if (m_run + 1 >= 16) m_to16 <= 1'b1;
            if (m_run + 1 >= 4)  m_to4  <= 1'b1;
         end else begin
            m_run <= 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("ctrl", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
                       id_ex_bubble, ex_mem_flush, mem_wb_bubble}),
          64'(exp_ctrl()));
      chk("ctrl4", 64'({pc_en4, if_id_en4, id_ex_en4, ex_mem_en4,
                        if_id_flush4, id_ex_bubble4, ex_mem_flush4,
                        mem_wb_bubble4}), 64'(exp_ctrl()));
      chk("fwd_a", 64'(fwd_a), 64'(exp_fwd(ex_rs1)));
      chk("fwd_b", 64'(fwd_b), 64'(exp_fwd(ex_rs2)));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
      chk("timeout16", 64'(mem_timeout), 64'(m_to16));
      chk("timeout4", 64'(mem_timeout4), 64'(m_to4));
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_opcode = 7'h13; id_rs1 = 0; id_rs2 = 0;
      id_ex_rd = 0; id_ex_is_load = 0; ex_rs1 = 0; ex_rs2 = 0;
      ex_mem_rd = 0; ex_mem_regwrite = 0; ex_mem_is_branch = 0;
      ex_mem_mem_req = 0; mem_ready = 0;
      mem_wb_rd = 0; mem_wb_regwrite = 0;
   endtask

   task automatic randin();
      id_opcode = 7'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_ex_rd = 5'($urandom_range(0, 7)); id_ex_is_load = 1'($urandom);
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
      ex_mem_rd = 5'($urandom_range(0, 7)); ex_mem_regwrite = 1'($urandom);
      ex_mem_is_branch = ($urandom_range(0, 5) == 0);
      ex_mem_mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = 1'($urandom);
      mem_wb_rd = 5'($urandom_range(0, 7)); mem_wb_regwrite = 1'($urandom);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      randin();
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("rst_pc_en", 64'(pc_en), 64'd0);
         chk("rst_flush", 64'({if_id_flush, id_ex_bubble, ex_mem_flush}), 64'd7);
         tick(1);
         randin();
      end
      idle();
      rst = 1'b1;
      #2;
      chk("post_rst_en", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 64'hF);
      chk("post_rst_fwd", 64'({fwd_a, fwd_b}), 64'd0);
      tick(1);

      // forwarding priority
      ex_rs1 = 5; ex_mem_rd = 5; ex_mem_regwrite = 1;
      mem_wb_rd = 5; mem_wb_regwrite = 1;
      #2; chk("fwd_mem", 64'(fwd_a), 64'd2);
      tick(1); ex_mem_regwrite = 0;
      #2; chk("fwd_wb", 64'(fwd_a), 64'd1);
      tick(1); ex_mem_rd = 0; mem_wb_rd = 0; ex_mem_regwrite = 1;
      #2; chk("fwd_x0", 64'(fwd_a), 64'd0);
      tick(1); idle();

      // load-use on rs2, then LUI which reads neither source
      id_ex_is_load = 1; id_ex_rd = 7; id_opcode = 7'b0110011; id_rs2 = 7;
      #2;
      chk("lu_pc_en", 64'(pc_en), 64'd0);
      chk("lu_bubble", 64'({if_id_en, id_ex_bubble, id_ex_en}), 64'b011);
      tick(1); idle();
      #2; chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      id_ex_is_load = 1; id_ex_rd = 7; id_opcode = 7'b0110111;
      id_rs1 = 7; id_rs2 = 7;
      #2; chk("lui_no_stall", 64'(pc_en), 64'd1);
      tick(1); idle();

      // taken branch
      ex_mem_is_branch = 1;
      #2;
      chk("br_flush", 64'({pc_en, if_id_flush, id_ex_bubble, ex_mem_flush}),
          64'hF);
      tick(1); idle();
      #2; chk("br_flush_cnt", 64'(flush_cnt), 64'd1);

      // 4-cycle memory wait
      ex_mem_mem_req = 1; mem_ready = 0;
      #2; chk("mw_freeze", 64'({pc_en, ex_mem_en, mem_wb_bubble}), 64'b001);
      tick(3);
      #2; chk("mw4_before", 64'(mem_timeout4), 64'd0);
      tick(1);
      #2; chk("mw4_at", 64'(mem_timeout4), 64'd1);
      mem_ready = 1;
      tick(1); idle();
      #2;
      chk("mw_stall_cnt", 64'(stall_cnt), 64'd5);
      chk("mw_no_to", 64'(mem_timeout), 64'd0);

      // reset in the middle of a wait
      ex_mem_mem_req = 1; mem_ready = 0;
      tick(2);
      rst = 1'b0;
      #2;
      chk("midrst_cnt", 64'(stall_cnt), 64'd0);
      chk("midrst_to", 64'(mem_timeout4), 64'd0);
      tick(1); idle(); rst = 1'b1;
      tick(1);

      // 6-cycle wait against MAX_WAIT=4
      ex_mem_mem_req = 1; mem_ready = 0;
      tick(6);
      #2;
      chk("w6_to4", 64'(mem_timeout4), 64'd1);
      chk("w6_to16", 64'(mem_timeout), 64'd0);
      mem_ready = 1;
      tick(1); idle();
      tick(2);
      chk("w6_held", 64'(mem_timeout4), 64'd1);

      // MAX_WAIT=16 boundary
      ex_mem_mem_req = 1; mem_ready = 0;
      tick(15);
      #2; chk("w16_before", 64'(mem_timeout), 64'd0);
      tick(1);
      #2; chk("w16_at", 64'(mem_timeout), 64'd1);
      mem_ready = 1;
      tick(1); idle();

      // priority: freeze over branch over load-use
      rst = 1'b0; tick(1); rst = 1'b1; tick(1);
      ex_mem_mem_req = 1; mem_ready = 0; ex_mem_is_branch = 1;
      id_ex_is_load = 1; id_ex_rd = 3; id_opcode = 7'b0110011; id_rs1 = 3;
      #2;
      chk("prio_frz", 64'({pc_en, if_id_flush, id_ex_bubble, ex_mem_flush,
                           mem_wb_bubble}), 64'b00001);
      tick(2);
      mem_ready = 1;
      #2;
      chk("prio_br", 64'({pc_en, if_id_flush, id_ex_bubble, mem_wb_bubble}),
          64'b1110);
      tick(1); idle();
      #2;
      chk("prio_flush_cnt", 64'(flush_cnt), 64'd1);
      chk("prio_stall_cnt", 64'(stall_cnt), 64'd2);

      // random sweep, checked by the per-cycle compare
      for (int i = 0; i < 400; i++) begin
         randin();
         tick(1);
      end
      idle();
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
